fb_writer: RTL and testbench

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_writer_if.sv | 27 ++
 rtl/fb_writer.sv | 140 ++++++++++++++
 tb/tb_fb_writer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fb_writer_if.sv
// Pixel, swap and framebuffer-memory signals between the GPU side, fb_writer and memory.
// The slave modport is the fb_writer view; master is the GPU/memory-side view.
interface fb_writer_if;
    logic [7:0]  fb_x;
    logic [7:0]  fb_y;
    logic [15:0] fb_color;
    logic        fb_write;
    logic        fb_full;
    logic        swap_req;
    logic        swap_done;
    logic        front_sel;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic        mem_ready;
    logic        overflow;

    modport slave (
        input  fb_x, fb_y, fb_color, fb_write, swap_req, mem_ready,
        output fb_full, swap_done, front_sel, mem_addr, mem_wdata, mem_write, overflow
    );

    modport master (
        output fb_x, fb_y, fb_color, fb_write, swap_req, mem_ready,
        input  fb_full, swap_done, front_sel, mem_addr, mem_wdata, mem_write, overflow
    );
endinterface

// File: rtl/fb_writer.sv
// Double-buffered framebuffer writer: filters GPU pixels into a small FIFO and drains
// them to memory, one write per accepted cycle, with front/back buffer swapping.
module fb_writer #(
    parameter int unsigned FB_WIDTH     = 160,
    parameter int unsigned FB_HEIGHT    = 120,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [15:0] TRANSP_COLOR = 16'hF81F
) (
    input logic         clk,
    input logic         rst,
    fb_writer_if.slave  fb_io
);

    localparam int unsigned AW = 17;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] BUF_WORDS = AW'(FB_WIDTH * FB_HEIGHT);

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] color;
    } pix_t;

    typedef enum logic [1:0] {IDLE, WRITE, SWAP_WAIT} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pending_q, pending_d;
    logic            front_sel_q, front_sel_d;
    logic            swap_done_q, swap_done_d;
    logic            overflow_q, overflow_d;
    logic            mem_write_q, mem_write_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]     mem_wdata_q, mem_wdata_d;
    pix_t            fifo_q [FIFO_DEPTH];

    logic            fb_full_c, push_c, pop_c, accept_c, slot_free_c, in_range_c;
    pix_t            head_c, pix_in_c;

    // Handshake qualifiers; a write slot frees up when nothing is outstanding or it is accepted now.
    always_comb begin
        fb_full_c   = (count_q == CW'(FIFO_DEPTH)) || (state_q == SWAP_WAIT) || pending_q;
        in_range_c  = (32'(fb_io.fb_x) < FB_WIDTH) && (32'(fb_io.fb_y) < FB_HEIGHT);
        push_c      = fb_io.fb_write && !fb_full_c && in_range_c && (fb_io.fb_color != TRANSP_COLOR);
        accept_c    = mem_write_q && fb_io.mem_ready;
        slot_free_c = !mem_write_q || accept_c;
        pop_c       = slot_free_c && (count_q != '0);
        head_c      = fifo_q[rd_ptr_q];
        pix_in_c    = '{x: fb_io.fb_x, y: fb_io.fb_y, color: fb_io.fb_color};
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        front_sel_d = front_sel_q;
        swap_done_d = 1'b0;
        overflow_d  = overflow_q | (fb_io.fb_write & fb_full_c);
        wr_ptr_d    = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push_c) - CW'(pop_c);
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (pop_c) begin
            mem_write_d = 1'b1;
            mem_addr_d  = (front_sel_q ? AW'(0) : BUF_WORDS)
                        + AW'(head_c.y) * AW'(FB_WIDTH) + AW'(head_c.x);
            mem_wdata_d = head_c.color;
        end else if (accept_c) begin
            mem_write_d = 1'b0;
        end

        case (state_q)
            IDLE, WRITE: begin
                if ((pending_q || fb_io.swap_req) && slot_free_c) begin
                    state_d   = SWAP_WAIT;
                    pending_d = 1'b0;
                end else begin
                    if (fb_io.swap_req) pending_d = 1'b1;
                    if (pop_c)            state_d = WRITE;
                    else if (slot_free_c) state_d = IDLE;
                end
            end
            SWAP_WAIT: begin
                if ((count_q == '0) && slot_free_c) begin
                    state_d     = IDLE;
                    front_sel_d = ~front_sel_q;
                    swap_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            overflow_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
            overflow_q  <= overflow_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Pixel storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_c) fifo_q[wr_ptr_q] <= pix_in_c;
    end

    assign fb_io.fb_full   = fb_full_c;
    assign fb_io.swap_done = swap_done_q;
    assign fb_io.front_sel = front_sel_q;
    assign fb_io.mem_addr  = mem_addr_q;
    assign fb_io.mem_wdata = mem_wdata_q;
    assign fb_io.mem_write = mem_write_q;
    assign fb_io.overflow  = overflow_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: single-pixel vector table plus hand-written
// backpressure, swap and mid-write reset sequences.
module tb_fb_writer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fb_writer_if bus ();

    fb_writer dut (
        .clk   (clk),
        .rst   (rst),
        .fb_io (bus)
    );

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] color;
        logic        wr;
        logic [16:0] addr;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [15:0] c);
        bus.fb_x     = x;
        bus.fb_y     = y;
        bus.fb_color = c;
        bus.fb_write = 1'b1;
        tick();
        bus.fb_write = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.fb_write = 1'b0;
        bus.swap_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        checks       = 0;
        failures     = 0;
        bus.fb_x     = '0;
        bus.fb_y     = '0;
        bus.fb_color = '0;
        bus.fb_write = 1'b0;
        bus.swap_req = 1'b0;
        bus.mem_ready = 1'b1;

        // Back buffer is 1 after reset, so addresses start at 160*120 = 19200.
        tbl[0] = '{x: 8'd1,   y: 8'd1,   color: 16'h1234, wr: 1'b1, addr: 17'd19361};
        tbl[1] = '{x: 8'd160, y: 8'd0,   color: 16'hAAAA, wr: 1'b0, addr: 17'd0};
        tbl[2] = '{x: 8'd0,   y: 8'd120, color: 16'hBBBB, wr: 1'b0, addr: 17'd0};
        tbl[3] = '{x: 8'd3,   y: 8'd3,   color: 16'hF81F, wr: 1'b0, addr: 17'd0};
        tbl[4] = '{x: 8'd159, y: 8'd119, color: 16'hBEEF, wr: 1'b1, addr: 17'd38399};
        tbl[5] = '{x: 8'd0,   y: 8'd0,   color: 16'h0001, wr: 1'b1, addr: 17'd19200};
        tbl[6] = '{x: 8'd255, y: 8'd255, color: 16'h1111, wr: 1'b0, addr: 17'd0};
        tbl[7] = '{x: 8'd10,  y: 8'd2,   color: 16'h5555, wr: 1'b1, addr: 17'd19530};

        tick();
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_swap_done", 32'(bus.swap_done), 32'd0);
        chk("rst_front_sel", 32'(bus.front_sel), 32'd0);
        chk("rst_overflow",  32'(bus.overflow),  32'd0);
        chk("rst_fb_full",   32'(bus.fb_full),   32'd0);
        do_reset();
        chk("post_rst_no_write", 32'(bus.mem_write), 32'd0);

        // Single pixels with an always-ready memory: write appears one edge after enqueue.
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].x, tbl[i].y, tbl[i].color);
            tick();
            chk($sformatf("vec%0d_write", i), 32'(bus.mem_write), 32'(tbl[i].wr));
            if (tbl[i].wr) begin
                chk($sformatf("vec%0d_addr", i),  32'(bus.mem_addr),  32'(tbl[i].addr));
                chk($sformatf("vec%0d_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].color));
            end
            tick();
            chk($sformatf("vec%0d_idle", i), 32'(bus.mem_write), 32'd0);
        end
        chk("vec_overflow", 32'(bus.overflow), 32'd0);

        // Backpressure: first pixel sits in the memory stage, next four fill the FIFO, sixth drops.
        do_reset();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(20 + i), 8'd5, 16'(16'h0100 + i));
        chk("bp_full", 32'(bus.fb_full), 32'd1);
        chk("bp_no_ovf_yet", 32'(bus.overflow), 32'd0);
        push(8'd30, 8'd5, 16'h0105);
        chk("bp_overflow", 32'(bus.overflow), 32'd1);
        chk("bp_still_full", 32'(bus.fb_full), 32'd1);
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_wr%0d", k),    32'(bus.mem_write), 32'd1);
            chk($sformatf("bp_addr%0d", k),  32'(bus.mem_addr),  32'(20020 + k));
            chk($sformatf("bp_wdata%0d", k), 32'(bus.mem_wdata), 32'(16'h0100 + k));
            tick();
        end
        chk("bp_drained", 32'(bus.mem_write), 32'd0);
        chk("bp_not_full", 32'(bus.fb_full), 32'd0);
        chk("bp_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Swap with three queued pixels and a repeated request while pending.
        do_reset();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(7 + i), 8'd2, 16'(16'hC000 + i));
        bus.swap_req = 1'b1;
        tick();
        chk("sw_full_now", 32'(bus.fb_full), 32'd1);
        tick();
        bus.swap_req = 1'b0;
        chk("sw_no_done_yet", 32'(bus.swap_done), 32'd0);
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sw_wr%0d", k),    32'(bus.mem_write), 32'd1);
            chk($sformatf("sw_addr%0d", k),  32'(bus.mem_addr),  32'(19527 + k));
            chk($sformatf("sw_wdata%0d", k), 32'(bus.mem_wdata), 32'(16'hC000 + k));
            tick();
        end
        chk("sw_done", 32'(bus.swap_done), 32'd1);
        chk("sw_front", 32'(bus.front_sel), 32'd1);
        chk("sw_write_off", 32'(bus.mem_write), 32'd0);
        tick();
        chk("sw_done_pulse", 32'(bus.swap_done), 32'd0);
        chk("sw_front_hold", 32'(bus.front_sel), 32'd1);
        chk("sw_full_clear", 32'(bus.fb_full), 32'd0);
        push(8'd0, 8'd0, 16'h7777);
        tick();
        chk("sw_new_write", 32'(bus.mem_write), 32'd1);
        chk("sw_new_addr",  32'(bus.mem_addr),  32'd0);
        chk("sw_new_wdata", 32'(bus.mem_wdata), 32'h7777);
        tick();
        chk("sw_single_done", 32'(bus.swap_done), 32'd0);

        // Reset while a write is stalled and two pixels wait in the FIFO.
        do_reset();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(40 + i), 8'd9, 16'(16'h0A00 + i));
        chk("mr_busy", 32'(bus.mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_write", 32'(bus.mem_write), 32'd0);
        chk("mr_async_addr",  32'(bus.mem_addr),  32'd0);
        chk("mr_async_wdata", 32'(bus.mem_wdata), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mr_quiet%0d", k), 32'(bus.mem_write), 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
